gbdt_ram_arbiter: RTL and testbench
===================================

GBDT_RAM_ARBITER -- requirements
Module: gbdt_ram_arbiter

Interface
REQ-001 SHALL have parameter N_BANKS, default 8, number of tree-RAM banks, one per classification engine.
REQ-002 SHALL have parameter MAX_WR_STREAK, default 4, consecutive write wins on a bank with a read pending before that read is forced through.
REQ-003 SHALL have port gbdt_clk  input  1  single clock, all state rising-edge.
REQ-004 SHALL have port gbdt_rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port run_active  input  1  classification in progress, writes blocked.
REQ-006 SHALL have port rd_req  input  N_BANKS  per-engine read request.
REQ-007 SHALL have port rd_addr  input  N_BANKS x RAM_ADDR_WIDTH  per-engine read address.
REQ-008 SHALL have port rd_gnt  output  N_BANKS  read accepted this cycle.
REQ-009 SHALL have port rd_valid  output  N_BANKS  bank read data valid on data_from_rams.
REQ-010 SHALL have port wr_req  input  1  model-loader write request.
REQ-011 SHALL have port wr_bank  input  3  target bank.
REQ-012 SHALL have port wr_addr  input  RAM_ADDR_WIDTH  write address.
REQ-013 SHALL have port wr_data  input  32  write word.
REQ-014 SHALL have port wr_gnt  output  1  write accepted this cycle.
REQ-015 SHALL have ports ram_cs, ram_we, ram_oe  output  N_BANKS each  per-bank RAM strobes.
REQ-016 SHALL have port ram_address  output  N_BANKS x RAM_ADDR_WIDTH  per-bank address.
REQ-017 SHALL have port ram_wdata  output  32  shared write data.

Function
REQ-018 Grants SHALL be combinational from current requests and registered state; a request is accepted when req and gnt are high in the same cycle (cycle N).
REQ-019 Accepted access SHALL drive ram_cs, ram_address and ram_oe (read) or ram_we plus ram_wdata (write) in cycle N+1, registered, for exactly one cycle.
REQ-020 rd_valid[i] SHALL be high in cycle N+2 for a read granted in cycle N; one-deep pipeline per bank, back-to-back reads giving back-to-back rd_valid.
REQ-021 With run_active high, wr_gnt SHALL be 0 and every rd_req SHALL be granted.
REQ-022 With run_active low and no contention (wr_req low or rd_req[wr_bank] low), all requests SHALL be granted.
REQ-023 On contention on bank wr_bank, write SHALL win unless streak[wr_bank] equals MAX_WR_STREAK, in which case the read wins and the streak clears.
REQ-024 streak[b] SHALL increment on each write win with rd_req[b] high, saturate at MAX_WR_STREAK, and clear when rd_gnt[b] is high or rd_req[b] is low.
REQ-025 Reads to banks other than wr_bank SHALL never be blocked by a write.
REQ-026 run_active rising while wr_req is held SHALL stall the write without loss; it is granted on the first cycle run_active is low.
REQ-027 rd_gnt and wr_gnt SHALL never both address one bank in one cycle; ram_we and ram_oe SHALL never both be high on a bank.

Reset
REQ-028 On gbdt_rst_n low, asynchronously: ram_cs, ram_we, ram_oe, rd_valid = 0; ram_address, ram_wdata = 0; all streak counters = 0.
REQ-029 Accesses granted in the cycle reset asserts SHALL be discarded; no rd_valid SHALL appear after reset release for them.

Structure
REQ-030 RAM_ADDR_WIDTH and N_BANKS default SHALL come from the shared GBDT define package alongside the existing constants.
REQ-031 One sub-module, gbdt_bank_port (per-bank grant, streak counter, strobe and rd_valid pipeline), SHALL be instantiated N_BANKS times.

Verification
REQ-032 run_active=1, rd_req=8'hFF, wr_req=1 -> rd_gnt=8'hFF, wr_gnt=0, ram_oe=8'hFF at N+1, rd_valid=8'hFF at N+2.
REQ-033 run_active=0, wr_req=1 wr_bank=3 wr_addr=5 wr_data=32'hDEADBEEF, no reads -> ram_we=8'h08, ram_address[3]=5, ram_wdata=32'hDEADBEEF at N+1.
REQ-034 Persistent wr_req bank 2 and rd_req[2] -> 4 write grants, 1 read grant, repeating; rd_valid[2] every fifth cycle.
REQ-035 rd_req[5] with continuous write to bank 2 -> rd_gnt[5] every cycle, streak[5] stays 0.
REQ-036 wr_req held, run_active 1 for 10 cycles then 0 -> wr_gnt first high the cycle run_active falls, single ram_we pulse.
REQ-037 Read granted, gbdt_rst_n pulsed low at N+1 -> strobes drop immediately, no rd_valid at N+2.

Source files
------------

// File: rtl/gbdt_ram_arbiter_pkg.sv
// Shared GBDT constants and types for the tree-RAM arbiter slice.
package gbdt_ram_arbiter_pkg;

    // Tree-RAM geometry shared by the engines, the model loader and the arbiter.
    localparam int RAM_ADDR_WIDTH    = 10;
    localparam int RAM_DATA_WIDTH    = 32;
    localparam int DEF_N_BANKS       = 8;
    localparam int WR_BANK_WIDTH     = 3;
    localparam int DEF_MAX_WR_STREAK = 4;

    // Per-bank arbitration outcome for the current cycle.
    typedef enum logic [1:0] {
        GNT_NONE  = 2'd0,
        GNT_READ  = 2'd1,
        GNT_WRITE = 2'd2
    } grant_e;

    // Width of a counter that must hold 0..max_streak inclusive.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/gbdt_ram_arbiter_if.sv
// Engine/loader request bus and per-bank RAM strobe bus of the tree-RAM arbiter.
interface gbdt_ram_arbiter_if
    import gbdt_ram_arbiter_pkg::*;
#(
    parameter int N_BANKS = DEF_N_BANKS,
    parameter int ADDR_W  = RAM_ADDR_WIDTH
) ();

    logic                                run_active;
    logic [N_BANKS-1:0]                  rd_req;
    logic [N_BANKS-1:0][ADDR_W-1:0]      rd_addr;
    logic [N_BANKS-1:0]                  rd_gnt;
    logic [N_BANKS-1:0]                  rd_valid;
    logic                                wr_req;
    logic [WR_BANK_WIDTH-1:0]            wr_bank;
    logic [ADDR_W-1:0]                   wr_addr;
    logic [RAM_DATA_WIDTH-1:0]           wr_data;
    logic                                wr_gnt;
    logic [N_BANKS-1:0]                  ram_cs;
    logic [N_BANKS-1:0]                  ram_we;
    logic [N_BANKS-1:0]                  ram_oe;
    logic [N_BANKS-1:0][ADDR_W-1:0]      ram_address;
    logic [RAM_DATA_WIDTH-1:0]           ram_wdata;

    // Requesting side: engines, model loader, and the RAM macros it observes.
    modport master (
        output run_active, rd_req, rd_addr, wr_req, wr_bank, wr_addr, wr_data,
        input  rd_gnt, rd_valid, wr_gnt, ram_cs, ram_we, ram_oe, ram_address, ram_wdata
    );

    // Arbiter side.
    modport slave (
        input  run_active, rd_req, rd_addr, wr_req, wr_bank, wr_addr, wr_data,
        output rd_gnt, rd_valid, wr_gnt, ram_cs, ram_we, ram_oe, ram_address, ram_wdata
    );

endinterface

// File: rtl/gbdt_ram_arbiter_bank_port.sv
// One tree-RAM bank: read/write grant, write-streak fairness counter,
// registered RAM strobes and the read-data-valid pipeline stage.
module gbdt_bank_port
    import gbdt_ram_arbiter_pkg::*;
#(
    parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK,
    parameter int ADDR_W        = RAM_ADDR_WIDTH
) (
    input  logic              gbdt_clk,
    input  logic              gbdt_rst_n,
    input  logic              wr_hit,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [ADDR_W-1:0] wr_addr,
    output logic              rd_gnt,
    output logic              wr_gnt,
    output logic              ram_cs,
    output logic              ram_we,
    output logic              ram_oe,
    output logic [ADDR_W-1:0] ram_address,
    output logic              rd_valid
);

    localparam int                  STREAK_W   = streak_width(MAX_WR_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_WR_STREAK);

    grant_e              gnt;
    logic                streak_full;
    logic [STREAK_W-1:0] streak_q;
    logic [STREAK_W-1:0] streak_d;

    // Write wins contention until the pending read has lost MAX_WR_STREAK times in a row.
    always_comb begin
        streak_full = (streak_q == STREAK_MAX);
        gnt         = GNT_NONE;
        if (wr_hit && !(rd_req && streak_full)) begin
            gnt = GNT_WRITE;
        end else if (rd_req) begin
            gnt = GNT_READ;
        end
    end

    assign rd_gnt = (gnt == GNT_READ);
    assign wr_gnt = (gnt == GNT_WRITE);

    // Streak counts only write wins that starved a waiting read; any read grant or idle read resets it.
    always_comb begin
        streak_d = streak_q;
        if (!rd_req || rd_gnt) begin
            streak_d = '0;
        end else if (wr_gnt && !streak_full) begin
            streak_d = streak_q + STREAK_W'(1);
        end
    end

    // Streak counter register.
    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

    // RAM strobes follow the grant by one cycle and last exactly one cycle.
    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_address <= '0;
        end else begin
            ram_cs <= rd_gnt || wr_gnt;
            ram_we <= wr_gnt;
            ram_oe <= rd_gnt;
            if (wr_gnt) begin
                ram_address <= wr_addr;
            end else if (rd_gnt) begin
                ram_address <= rd_addr;
            end
        end
    end

    // Read data lands one cycle after the output-enable strobe.
    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= ram_oe;
        end
    end

    a_one_grant_per_bank : assert property (
        @(posedge gbdt_clk) disable iff (!gbdt_rst_n) !(rd_gnt && wr_gnt));

    a_we_oe_exclusive : assert property (
        @(posedge gbdt_clk) disable iff (!gbdt_rst_n) !(ram_we && ram_oe));

endmodule

// File: rtl/gbdt_ram_arbiter.sv
// Tree-RAM arbiter: N_BANKS engine read ports share each bank with a single
// model-loader write port. Writes are blocked while classification runs.
// N_BANKS must match the N_BANKS of the connected interface instance.
module gbdt_ram_arbiter
    import gbdt_ram_arbiter_pkg::*;
#(
    parameter int N_BANKS       = DEF_N_BANKS,
    parameter int MAX_WR_STREAK = DEF_MAX_WR_STREAK
) (
    input  logic               gbdt_clk,
    input  logic               gbdt_rst_n,
    gbdt_ram_arbiter_if.slave  bus
);

    logic [N_BANKS-1:0]                     wr_hit;
    logic [N_BANKS-1:0]                     rd_gnt_w;
    logic [N_BANKS-1:0]                     wr_gnt_w;
    logic [N_BANKS-1:0]                     ram_cs_w;
    logic [N_BANKS-1:0]                     ram_we_w;
    logic [N_BANKS-1:0]                     ram_oe_w;
    logic [N_BANKS-1:0]                     rd_valid_w;
    logic [N_BANKS-1:0][RAM_ADDR_WIDTH-1:0] ram_address_w;
    logic [RAM_DATA_WIDTH-1:0]              ram_wdata_q;

    for (genvar i = 0; i < N_BANKS; i++) begin : g_bank
        localparam logic [WR_BANK_WIDTH-1:0] BANK_ID = WR_BANK_WIDTH'(i);

        // A write only targets a bank while the engines are idle.
        assign wr_hit[i] = bus.wr_req && !bus.run_active && (bus.wr_bank == BANK_ID);

        gbdt_bank_port #(
            .MAX_WR_STREAK (MAX_WR_STREAK),
            .ADDR_W        (RAM_ADDR_WIDTH)
        ) u_port (
            .gbdt_clk    (gbdt_clk),
            .gbdt_rst_n  (gbdt_rst_n),
            .wr_hit      (wr_hit[i]),
            .rd_req      (bus.rd_req[i]),
            .rd_addr     (bus.rd_addr[i]),
            .wr_addr     (bus.wr_addr),
            .rd_gnt      (rd_gnt_w[i]),
            .wr_gnt      (wr_gnt_w[i]),
            .ram_cs      (ram_cs_w[i]),
            .ram_we      (ram_we_w[i]),
            .ram_oe      (ram_oe_w[i]),
            .ram_address (ram_address_w[i]),
            .rd_valid    (rd_valid_w[i])
        );
    end

    // Write data is shared by all banks; only capture it on an accepted write.
    always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
        if (!gbdt_rst_n) begin
            ram_wdata_q <= '0;
        end else if (|wr_gnt_w) begin
            ram_wdata_q <= bus.wr_data;
        end
    end

    assign bus.rd_gnt      = rd_gnt_w;
    assign bus.wr_gnt      = |wr_gnt_w;
    assign bus.rd_valid    = rd_valid_w;
    assign bus.ram_cs      = ram_cs_w;
    assign bus.ram_we      = ram_we_w;
    assign bus.ram_oe      = ram_oe_w;
    assign bus.ram_address = ram_address_w;
    assign bus.ram_wdata   = ram_wdata_q;

endmodule

// File: tb/tb_gbdt_ram_arbiter.sv
// Scoreboard bench for gbdt_ram_arbiter: a reference arbitration model predicts
// grants each cycle and queues the strobes and rd_valid the DUT must produce later.
module tb_gbdt_ram_arbiter;
    import gbdt_ram_arbiter_pkg::*;

    localparam int NB   = DEF_N_BANKS;
    localparam int MAXS = 4;
    localparam int AW   = RAM_ADDR_WIDTH;

    typedef struct {
        logic [NB-1:0]         cs;
        logic [NB-1:0]         we;
        logic [NB-1:0]         oe;
        logic [NB-1:0][AW-1:0] addr;
        logic [31:0]           wdata;
        logic                  wd_chk;
    } strobe_t;

    logic gbdt_clk   = 1'b0;
    logic gbdt_rst_n = 1'b0;

    gbdt_ram_arbiter_if #(.N_BANKS(NB), .ADDR_W(AW)) bus ();

    gbdt_ram_arbiter #(.N_BANKS(NB), .MAX_WR_STREAK(MAXS)) dut (
        .gbdt_clk   (gbdt_clk),
        .gbdt_rst_n (gbdt_rst_n),
        .bus        (bus)
    );

    always #5 gbdt_clk = ~gbdt_clk;

    int n_chk  = 0;
    int n_fail = 0;

    strobe_t       q_strobe[$];
    logic [NB-1:0] q_valid[$];

    int            m_streak[NB];
    logic [NB-1:0] e_rd;
    logic          e_wr;
    logic [NB-1:0] e_wr_oh;

    logic [NB-1:0] obs_rd;
    logic          obs_wr;
    logic [NB-1:0] obs_we;
    logic [NB-1:0] obs_valid;

    int cnt_a, cnt_b, cnt_c;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < NB; b++) m_streak[b] = 0;
        q_strobe.delete();
        q_valid.delete();
        q_valid.push_back('0);
    endtask

    task automatic model_grant();
        logic hit;
        e_rd    = '0;
        e_wr    = 1'b0;
        e_wr_oh = '0;
        for (int b = 0; b < NB; b++) begin
            hit = bus.wr_req && !bus.run_active && (int'(bus.wr_bank) == b);
            if (!hit) begin
                e_rd[b] = bus.rd_req[b];
            end else if (bus.rd_req[b] && m_streak[b] == MAXS) begin
                e_rd[b] = 1'b1;
            end else begin
                e_wr       = 1'b1;
                e_wr_oh[b] = 1'b1;
            end
        end
    endtask

    task automatic model_update();
        for (int b = 0; b < NB; b++) begin
            if (e_rd[b] || !bus.rd_req[b]) m_streak[b] = 0;
            else if (e_wr_oh[b] && m_streak[b] < MAXS) m_streak[b]++;
        end
    endtask

    // Called at a falling edge with inputs already driven; returns at the next falling edge.
    task automatic step();
        strobe_t r;
        logic [NB-1:0] v;
        #1;
        model_grant();
        obs_rd = bus.rd_gnt;
        obs_wr = bus.wr_gnt;
        chk("rd_gnt", 64'(bus.rd_gnt), 64'(e_rd));
        chk("wr_gnt", 64'(bus.wr_gnt), 64'(e_wr));
        r.cs     = e_rd | e_wr_oh;
        r.we     = e_wr_oh;
        r.oe     = e_rd;
        for (int b = 0; b < NB; b++) r.addr[b] = e_wr_oh[b] ? bus.wr_addr : bus.rd_addr[b];
        r.wdata  = bus.wr_data;
        r.wd_chk = e_wr;
        q_strobe.push_back(r);
        q_valid.push_back(e_rd);
        @(posedge gbdt_clk);
        model_update();
        @(negedge gbdt_clk);
        r = q_strobe.pop_front();
        v = q_valid.pop_front();
        chk("ram_cs", 64'(bus.ram_cs), 64'(r.cs));
        chk("ram_we", 64'(bus.ram_we), 64'(r.we));
        chk("ram_oe", 64'(bus.ram_oe), 64'(r.oe));
        for (int b = 0; b < NB; b++)
            if (r.cs[b]) chk("ram_address", 64'(bus.ram_address[b]), 64'(r.addr[b]));
        if (r.wd_chk) chk("ram_wdata", 64'(bus.ram_wdata), 64'(r.wdata));
        chk("rd_valid", 64'(bus.rd_valid), 64'(v));
        obs_we    = bus.ram_we;
        obs_valid = bus.rd_valid;
    endtask

    task automatic idle_inputs();
        bus.run_active = 1'b0;
        bus.rd_req     = '0;
        bus.wr_req     = 1'b0;
        bus.wr_bank    = '0;
        bus.wr_addr    = '0;
        bus.wr_data    = '0;
        for (int b = 0; b < NB; b++) bus.rd_addr[b] = AW'(b * 16 + 1);
    endtask

    initial begin
        idle_inputs();
        model_reset();
        repeat (2) @(negedge gbdt_clk);
        chk("reset_ram_cs",    64'(bus.ram_cs),    64'(0));
        chk("reset_ram_we",    64'(bus.ram_we),    64'(0));
        chk("reset_ram_oe",    64'(bus.ram_oe),    64'(0));
        chk("reset_rd_valid",  64'(bus.rd_valid),  64'(0));
        chk("reset_ram_wdata", 64'(bus.ram_wdata), 64'(0));
        gbdt_rst_n = 1'b1;

        // Running engines: every read granted, loader write held off.
        bus.run_active = 1'b1;
        bus.rd_req     = 8'hFF;
        bus.wr_req     = 1'b1;
        bus.wr_bank    = 3'd0;
        step();
        chk("run_rd_gnt", 64'(obs_rd), 64'(8'hFF));
        chk("run_wr_gnt", 64'(obs_wr), 64'(0));
        chk("run_ram_oe", 64'(bus.ram_oe), 64'(8'hFF));
        idle_inputs();
        step();
        chk("run_rd_valid", 64'(obs_valid), 64'(8'hFF));
        step();

        // Single uncontended write.
        bus.wr_req  = 1'b1;
        bus.wr_bank = 3'd3;
        bus.wr_addr = AW'(5);
        bus.wr_data = 32'hDEADBEEF;
        step();
        chk("wr_ram_we",    64'(bus.ram_we),         64'(8'h08));
        chk("wr_ram_addr3", 64'(bus.ram_address[3]), 64'(5));
        chk("wr_ram_wdata", 64'(bus.ram_wdata),      64'(32'hDEADBEEF));
        idle_inputs();
        step();

        // Persistent contention on bank 2: four writes then one read, repeating.
        bus.wr_req    = 1'b1;
        bus.wr_bank   = 3'd2;
        bus.rd_req[2] = 1'b1;
        cnt_a = 0; cnt_b = 0; cnt_c = 0;
        for (int k = 0; k < 15; k++) begin
            bus.wr_addr = AW'(k + 100);
            bus.wr_data = 32'h1000 + k;
            step();
            cnt_a += int'(obs_wr);
            cnt_b += int'(obs_rd[2]);
            cnt_c += int'(obs_valid[2]);
            if (k == 3) chk("streak_4th_is_write", 64'(obs_wr), 64'(1));
            if (k == 4) chk("streak_5th_is_read",  64'(obs_rd[2]), 64'(1));
        end
        chk("contend_wr_count",    64'(cnt_a), 64'(12));
        chk("contend_rd_count",    64'(cnt_b), 64'(3));
        chk("contend_valid_count", 64'(cnt_c), 64'(2));

        // Read on another bank is never blocked by continuous writes to bank 2.
        bus.rd_req = 8'h20;
        cnt_a = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            cnt_a += int'(obs_rd[5]);
        end
        chk("other_bank_rd_count", 64'(cnt_a), 64'(10));
        // Contention on bank 5 now must grant the write first: streak[5] stayed at 0.
        bus.wr_bank = 3'd5;
        cnt_a = 0;
        for (int k = 0; k < 5; k++) begin
            step();
            cnt_a += int'(obs_wr);
        end
        chk("bank5_streak_was_zero", 64'(cnt_a), 64'(4));
        idle_inputs();
        step();

        // Write held across a run window is stalled, then issued once.
        bus.wr_req     = 1'b1;
        bus.wr_bank    = 3'd1;
        bus.wr_addr    = AW'(77);
        bus.wr_data    = 32'hCAFE0001;
        bus.run_active = 1'b1;
        cnt_a = 0; cnt_b = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            cnt_a += int'(obs_wr);
            cnt_b += int'(obs_we != '0);
        end
        chk("stall_no_wr_gnt", 64'(cnt_a), 64'(0));
        bus.run_active = 1'b0;
        step();
        chk("stall_release_gnt", 64'(obs_wr), 64'(1));
        cnt_b += int'(obs_we != '0);
        bus.wr_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            step();
            cnt_b += int'(obs_we != '0);
        end
        chk("stall_we_pulses", 64'(cnt_b), 64'(1));

        // Random traffic against the reference model.
        for (int k = 0; k < 300; k++) begin
            bus.run_active = ($urandom_range(0, 3) == 0);
            bus.rd_req     = NB'($urandom);
            bus.wr_req     = ($urandom_range(0, 2) != 0);
            bus.wr_bank    = 3'($urandom_range(0, 7));
            bus.wr_addr    = AW'($urandom);
            bus.wr_data    = $urandom;
            for (int b = 0; b < NB; b++) bus.rd_addr[b] = AW'($urandom);
            step();
        end
        idle_inputs();
        step();
        step();

        // Reset pulse while a granted read is on the strobes.
        bus.rd_req = 8'h01;
        step();
        chk("pre_reset_ram_oe", 64'(bus.ram_oe), 64'(8'h01));
        bus.rd_req = '0;
        gbdt_rst_n = 1'b0;
        #1;
        chk("async_reset_ram_oe", 64'(bus.ram_oe), 64'(0));
        chk("async_reset_ram_cs", 64'(bus.ram_cs), 64'(0));
        #1;
        gbdt_rst_n = 1'b1;
        model_reset();
        step();
        chk("post_reset_no_valid", 64'(obs_valid), 64'(0));
        step();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
